// File: rtl/pipe_stage_buffer_pkg.sv
// Shared widths and encodings for the elastic stage buffers.
// Each stage packs its own payload layout into a flat vector.
package pipe_stage_buffer_pkg;

    localparam int ROB_ENTRY_WIDTH = 6;
    localparam int WORD_SIZE       = 32;

    // Stage payload widths
    localparam int DE_PAYLOAD_W = 2 * WORD_SIZE;
    localparam int EX_PAYLOAD_W = 2 * WORD_SIZE;
    localparam int MW_PAYLOAD_W = WORD_SIZE + 8;

    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } buf_op_e;

endpackage

// File: rtl/pipe_slot_array.sv
// DEPTH x {live, rob_id, data} slot file for the stage buffer.
// One write port, async head read, kill CAM and bulk live clear.
module pipe_slot_array #(
    parameter int DEPTH     = 2,
    parameter int PAYLOAD_W = 64,
    parameter int ROB_W     = 6,
    parameter int PTR_W     = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 wr_en,
    input  logic [PTR_W-1:0]     wr_ptr,
    input  logic                 wr_live,
    input  logic [ROB_W-1:0]     wr_rob_id,
    input  logic [PAYLOAD_W-1:0] wr_data,
    input  logic [PTR_W-1:0]     rd_ptr,
    output logic                 rd_live,
    output logic [ROB_W-1:0]     rd_rob_id,
    output logic [PAYLOAD_W-1:0] rd_data,
    input  logic                 kill_valid,
    input  logic [ROB_W-1:0]     kill_rob_id
);

    import pipe_stage_buffer_pkg::*;

    logic                 live_q [DEPTH];
    logic [ROB_W-1:0]     rob_q  [DEPTH];
    logic [PAYLOAD_W-1:0] data_q [DEPTH];

    // Written slot overrides the CAM so a same-cycle kill of the
    // incoming id is decided by wr_live alone.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                live_q[i] <= 1'b0;
                rob_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                live_q[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (kill_valid && (rob_q[i] == kill_rob_id)) begin
                    live_q[i] <= 1'b0;
                end
            end
            if (wr_en) begin
                live_q[wr_ptr] <= wr_live;
                rob_q[wr_ptr]  <= wr_rob_id;
                data_q[wr_ptr] <= wr_data;
            end
        end
    end

    assign rd_live   = live_q[rd_ptr];
    assign rd_rob_id = rob_q[rd_ptr];
    assign rd_data   = data_q[rd_ptr];

endmodule

// File: rtl/pipe_stage_buffer.sv
// Elastic DEPTH-entry buffer between two pipeline stages with
// valid/ready on both sides, full flush and per-ROB-id squash.
module pipe_stage_buffer #(
    parameter int PAYLOAD_W       = 64,
    parameter int ROB_ENTRY_WIDTH = pipe_stage_buffer_pkg::ROB_ENTRY_WIDTH,
    parameter int DEPTH           = 2,
    localparam int PTR_W          = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [PAYLOAD_W-1:0]       in_data,
    input  logic [ROB_ENTRY_WIDTH-1:0] in_rob_id,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [PAYLOAD_W-1:0]       out_data,
    output logic [ROB_ENTRY_WIDTH-1:0] out_rob_id,
    input  logic                       flush,
    input  logic                       kill_valid,
    input  logic [ROB_ENTRY_WIDTH-1:0] kill_rob_id,
    output logic [PTR_W:0]             count
);

    import pipe_stage_buffer_pkg::*;

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [PTR_W-1:0]           head;
    logic [PTR_W-1:0]           tail;
    logic [PTR_W:0]             occ;
    logic                       head_live;
    logic [ROB_ENTRY_WIDTH-1:0] head_rob_id;
    logic [PAYLOAD_W-1:0]       head_data;
    logic                       nonempty;
    logic                       full;
    logic                       push;
    logic                       pop;
    logic                       incoming_live;
    buf_op_e                    op;

    assign nonempty = (occ != '0);
    assign full     = (occ == FULL_CNT);

    // Registered-only readiness: no path from out_ready to in_ready.
    assign in_ready = !full;
    assign push     = in_valid && in_ready;

    assign out_valid  = nonempty && head_live;
    assign out_data   = head_data;
    assign out_rob_id = head_rob_id;
    assign count      = occ;

    // A dead head is retired without a downstream handshake.
    assign pop = nonempty && (!head_live || out_ready);

    assign incoming_live = !(kill_valid && (kill_rob_id == in_rob_id));

    always_comb begin
        op = OP_IDLE;
        unique case ({push, pop})
            2'b00: op = OP_IDLE;
            2'b01: op = OP_POP;
            2'b10: op = OP_PUSH;
            2'b11: op = OP_BOTH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head <= '0;
            tail <= '0;
            occ  <= '0;
        end else if (flush) begin
            head <= '0;
            tail <= '0;
            occ  <= '0;
        end else begin
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            unique case (op)
                OP_PUSH: occ <= occ + 1'b1;
                OP_POP:  occ <= occ - 1'b1;
                OP_IDLE: occ <= occ;
                OP_BOTH: occ <= occ;
            endcase
        end
    end

    pipe_slot_array #(
        .DEPTH     (DEPTH),
        .PAYLOAD_W (PAYLOAD_W),
        .ROB_W     (ROB_ENTRY_WIDTH),
        .PTR_W     (PTR_W)
    ) u_slots (
        .clk         (clk),
        .reset       (reset),
        .clear       (flush),
        .wr_en       (push),
        .wr_ptr      (tail),
        .wr_live     (incoming_live),
        .wr_rob_id   (in_rob_id),
        .wr_data     (in_data),
        .rd_ptr      (head),
        .rd_live     (head_live),
        .rd_rob_id   (head_rob_id),
        .rd_data     (head_data),
        .kill_valid  (kill_valid),
        .kill_rob_id (kill_rob_id)
    );

    occ_bound: assert property (
        @(posedge clk) disable iff (!reset) occ <= FULL_CNT
    );

endmodule
